// File: rtl/fetch_controller_if.sv
// Fetch-side bus: instruction-memory read port, decode handshake and branch redirect.
// The fetch controller is the master; memory/decode/branch logic sits on the slave side.
interface fetch_controller_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;

    modport master (
        output imem_addr,
        input  imem_instr,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the pc, registers one instruction for decode,
// handles branch redirects, stops on HALT and counts delivered instructions.
module fetch_controller #(
    parameter int                ADDR_W      = 8,
    parameter int                INSTR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]        HALT_OPCODE = 4'hF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    fetch_controller_if.master   bus,
    output logic                 busy,
    output logic                 halted,
    output logic [15:0]          instr_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
    logic [15:0]        instr_count_q, instr_count_d;

    logic handshake;
    logic slot_free;
    logic is_halt;

    assign handshake = if_valid_q & bus.if_ready;
    assign slot_free = ~if_valid_q | bus.if_ready;
    assign is_halt   = (bus.imem_instr[INSTR_W-1 -: 4] == HALT_OPCODE);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        instr_count_d = instr_count_q;

        // Delivered instructions are counted in every state, including the cycle of a flush.
        if (handshake && (instr_count_q != 16'hFFFF)) begin
            instr_count_d = instr_count_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if_instr_d = bus.imem_instr;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + ADDR_W'(1);
                    state_d    = RUN;
                end
            end

            RUN: begin
                if (bus.redirect_valid) begin
                    if_valid_d = 1'b0;
                    pc_d       = bus.redirect_pc;
                end else if (slot_free) begin
                    if_instr_d = bus.imem_instr;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + ADDR_W'(1);
                    if (is_halt) begin
                        state_d = HALTED;
                    end
                end
            end

            HALTED: begin
                // The HALT word itself may still be waiting for decode; let it drain.
                if (start) begin
                    pc_d       = RESET_PC;
                    if_valid_d = 1'b0;
                    state_d    = IDLE;
                end else if (handshake) begin
                    if_valid_d = 1'b0;
                end
            end

            default: begin
                state_d    = IDLE;
                pc_d       = RESET_PC;
                if_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;
    assign busy          = (state_q == RUN);
    assign halted        = (state_q == HALTED);
    assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: directed stimulus pushes expected (pc, instr)
// pairs; a negedge monitor pops one per completed handshake and compares.
module tb_fetch_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;

    logic [15:0] mem [256];

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } fetch_t;

    fetch_t expQ[$];

    int vectors;
    int miscompares;

    logic        prevValid;
    logic        prevReady;
    logic        prevRedirect;
    logic [15:0] prevInstr;
    logic [7:0]  prevPc;

    fetch_controller_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

    fetch_controller #(
        .ADDR_W(8),
        .INSTR_W(16),
        .RESET_PC(8'h00),
        .HALT_OPCODE(4'hF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .bus(bus.master),
        .busy(busy),
        .halted(halted),
        .instr_count(instr_count)
    );

    assign bus.imem_instr = mem[bus.imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive the inputs for the coming edge, then step to just after it.
    task automatic applyStimulus(input logic s, input logic r, input logic rv, input logic [7:0] rpc);
        start              = s;
        bus.if_ready       = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [7:0] pc, input logic [15:0] instr);
        expQ.push_back({pc, instr});
    endtask

    // Monitor: every accepted instruction must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.if_valid && bus.if_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_delivery_pc", {24'd0, bus.if_pc}, 32'hFFFF_FFFF);
            end else begin
                fetch_t e;
                e = expQ.pop_front();
                checkOutput("delivered_pc", {24'd0, bus.if_pc}, {24'd0, e.pc});
                checkOutput("delivered_instr", {16'd0, bus.if_instr}, {16'd0, e.instr});
            end
        end
        if (rst_n && prevValid && !prevReady && !prevRedirect && bus.if_valid) begin
            checkOutput("stall_instr_stable", {16'd0, bus.if_instr}, {16'd0, prevInstr});
            checkOutput("stall_pc_stable", {24'd0, bus.if_pc}, {24'd0, prevPc});
        end
        prevValid    = rst_n & bus.if_valid;
        prevReady    = bus.if_ready;
        prevRedirect = bus.redirect_valid;
        prevInstr    = bus.if_instr;
        prevPc       = bus.if_pc;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors      = 0;
        miscompares  = 0;
        prevValid    = 1'b0;
        prevReady    = 1'b0;
        prevRedirect = 1'b0;
        prevInstr    = '0;
        prevPc       = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i + 1);
        mem[8'h40] = 16'h1234;

        rst_n              = 1'b0;
        start              = 1'b0;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 8'h00;

        // Reset state
        #22;
        checkOutput("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        checkOutput("rst_if_instr", {16'd0, bus.if_instr}, 32'd0);
        checkOutput("rst_if_pc", {24'd0, bus.if_pc}, 32'd0);
        checkOutput("rst_instr_count", {16'd0, instr_count}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("rst_imem_addr", {24'd0, bus.imem_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Start and stream addresses 0..4
        for (int i = 0; i < 5; i++) pushExp(8'(i), 16'(i + 1));
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("first_valid", {31'd0, bus.if_valid}, 32'd1);
        checkOutput("first_pc", {24'd0, bus.if_pc}, 32'd0);
        checkOutput("first_busy", {31'd0, busy}, 32'd1);
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("count_after_5", {16'd0, instr_count}, 32'd5);
        checkOutput("queue_empty_stream", expQ.size(), 32'd0);

        // Backpressure: pc 5 stays presented while decode stalls
        repeat (3) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
            checkOutput("bp_if_pc", {24'd0, bus.if_pc}, 32'h05);
            checkOutput("bp_if_instr", {16'd0, bus.if_instr}, 32'h0006);
            checkOutput("bp_imem_addr", {24'd0, bus.imem_addr}, 32'h06);
        end
        pushExp(8'h05, 16'h0006);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("bp_resume_pc", {24'd0, bus.if_pc}, 32'h06);
        checkOutput("bp_count", {16'd0, instr_count}, 32'd6);

        // Redirect to 2 while stalled: word at pc 6 is flushed, never accepted
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h02);
        checkOutput("flush_valid", {31'd0, bus.if_valid}, 32'd0);
        checkOutput("flush_addr", {24'd0, bus.imem_addr}, 32'h02);
        pushExp(8'h02, 16'h0003);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("at_pc3", {24'd0, bus.if_pc}, 32'h03);

        // Redirect at if_pc 3 to 0x40, with pc 3 taken in the same cycle
        pushExp(8'h03, 16'h0004);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h40);
        checkOutput("redir_bubble", {31'd0, bus.if_valid}, 32'd0);
        checkOutput("redir_addr", {24'd0, bus.imem_addr}, 32'h40);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("redir_target_valid", {31'd0, bus.if_valid}, 32'd1);
        checkOutput("redir_target_pc", {24'd0, bus.if_pc}, 32'h40);
        checkOutput("redir_target_instr", {16'd0, bus.if_instr}, 32'h1234);

        // Wrap: redirect to 0xFE and free-run through 0xFF -> 0x00
        pushExp(8'h40, 16'h1234);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hFE);
        pushExp(8'hFE, 16'h00FF);
        pushExp(8'hFF, 16'h0100);
        pushExp(8'h00, 16'h0001);
        pushExp(8'h01, 16'h0002);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("wrap_pc_fe", {24'd0, bus.if_pc}, 32'hFE);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("wrap_pc_ff", {24'd0, bus.if_pc}, 32'hFF);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("wrap_pc_00", {24'd0, bus.if_pc}, 32'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("wrap_pc_01", {24'd0, bus.if_pc}, 32'h01);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("wrap_hold_pc", {24'd0, bus.if_pc}, 32'h02);
        checkOutput("wrap_count", {16'd0, instr_count}, 32'd13);
        checkOutput("queue_empty_wrap", expQ.size(), 32'd0);

        // Asynchronous reset between edges while stalled
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'd0, bus.if_valid}, 32'd0);
        checkOutput("async_rst_count", {16'd0, instr_count}, 32'd0);
        checkOutput("async_rst_addr", {24'd0, bus.imem_addr}, 32'h00);
        checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // HALT at address 2
        mem[2] = 16'hF000;
        pushExp(8'h00, 16'h0001);
        pushExp(8'h01, 16'h0002);
        pushExp(8'h02, 16'hF000);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("halt_halted", {31'd0, halted}, 32'd1);
        checkOutput("halt_busy", {31'd0, busy}, 32'd0);
        checkOutput("halt_word_valid", {31'd0, bus.if_valid}, 32'd1);
        checkOutput("halt_word_pc", {24'd0, bus.if_pc}, 32'h02);
        checkOutput("halt_pc_next", {24'd0, bus.imem_addr}, 32'h03);
        repeat (3) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 8'h80);
            checkOutput("halted_no_valid", {31'd0, bus.if_valid}, 32'd0);
            checkOutput("halted_addr", {24'd0, bus.imem_addr}, 32'h03);
        end
        checkOutput("halt_count", {16'd0, instr_count}, 32'd3);

        // start -> IDLE, then a second start refetches from 0
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("idle_halted", {31'd0, halted}, 32'd0);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_addr", {24'd0, bus.imem_addr}, 32'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("idle_no_valid", {31'd0, bus.if_valid}, 32'd0);
        pushExp(8'h00, 16'h0001);
        pushExp(8'h01, 16'h0002);
        pushExp(8'h02, 16'hF000);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("restart_pc", {24'd0, bus.if_pc}, 32'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("restart_halted", {31'd0, halted}, 32'd1);
        checkOutput("restart_valid", {31'd0, bus.if_valid}, 32'd0);
        checkOutput("restart_count", {16'd0, instr_count}, 32'd6);
        checkOutput("queue_empty_end", expQ.size(), 32'd0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
